ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset) from the I/O block to the keyboard on the same PS/2 pair the keyboard receiver listens on. It runs the request-to-send sequence and shifts out 8 data bits, odd parity and stop in step with device-generated clocks. It then checks the device ACK and reports done or error. It drives the lines open-drain through output-enable pins; the top level ties them to tristate buffers on PS2_CLK/PS2_DAT.

---
 rtl/ps2_host_tx.sv | 158 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits, odd parity, stop, ACK check.
// Optional build macro PS2TX_ACK_CHECK_EN: a missing device ACK ends the transfer with error.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int START_CYCLES   = 32,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps_clk,
  input  logic       ps_dat,
  output logic       ps_clk_oe,
  output logic       ps_dat_oe,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int MAX_A   = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_START    = 3'd2;
  localparam logic [2:0] S_SHIFT    = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_WAITIDLE = 3'd5;

  logic [2:0]       state;
  logic [8:0]       shift_reg;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_d;
  logic             fe;
  logic             watched;
  logic             wd_expired;

  // Lines idle high, so the synchronisers come out of reset at 1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_d    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps_clk};
      dat_sync <= {dat_sync[0], ps_dat};
      clk_d    <= clk_sync[1];
    end
  end

  assign fe         = clk_d & ~clk_sync[1];
  assign watched    = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAITIDLE);
  assign wd_expired = (cnt == TMO_LAST);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ps_clk_oe <= 1'b0;
      ps_dat_oe <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      cnt       <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (watched && !fe && wd_expired) begin
        // Device went silent: let go of both lines and give up
        state     <= S_IDLE;
        ps_clk_oe <= 1'b0;
        ps_dat_oe <= 1'b0;
        error     <= 1'b1;
      end else begin
        if (watched) cnt <= fe ? '0 : cnt + 1'b1;
        case (state)
          S_IDLE: begin
            if (send) begin
              shift_reg <= {~^data, data};
              cnt       <= '0;
              ps_clk_oe <= 1'b1;
              state     <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (cnt == INH_LAST) begin
              cnt       <= '0;
              ps_dat_oe <= 1'b1;
              state     <= S_START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_START: begin
            // Releasing clock with data held low presents the start bit
            if (cnt == START_LAST) begin
              cnt       <= '0;
              ps_clk_oe <= 1'b0;
              bit_cnt   <= '0;
              state     <= S_SHIFT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SHIFT: begin
            if (fe) begin
              if (bit_cnt == 4'd9) begin
                ps_dat_oe <= 1'b0;
                state     <= S_ACK;
              end else begin
                ps_dat_oe <= ~shift_reg[0];
                shift_reg <= {1'b0, shift_reg[8:1]};
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
          end
          S_ACK: begin
            if (fe) begin
`ifdef PS2TX_ACK_CHECK_EN
              if (dat_sync[1]) begin
                state <= S_IDLE;
                error <= 1'b1;
              end else begin
                state <= S_WAITIDLE;
              end
`else
              state <= S_WAITIDLE;
`endif
            end
          end
          S_WAITIDLE: begin
            if (clk_sync[1] && dat_sync[1]) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
          default: begin
            state     <= S_IDLE;
            ps_clk_oe <= 1'b0;
            ps_dat_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, frame capture on rising clock edges.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int STC = 8;
  localparam int TMO = 300;
`ifdef PS2TX_ACK_CHECK_EN
  localparam logic ACK_CHK = 1'b1;
`else
  localparam logic ACK_CHK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps_clk, ps_dat, ps_clk_oe, ps_dat_oe;
  logic [7:0] data = 8'h00;
  logic       send = 1'b0;
  logic       busy, done, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps_clk = ~(ps_clk_oe | dev_clk_low);
  assign ps_dat = ~(ps_dat_oe | dev_dat_low);

  always #20 clock = ~clock;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_CYCLES(STC), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .ps_clk(ps_clk), .ps_dat(ps_dat),
    .ps_clk_oe(ps_clk_oe), .ps_dat_oe(ps_dat_oe), .data(data), .send(send),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    logic [7:0] d;
    logic       ack;
    logic       par;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  int tests = 0, fails = 0, cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
  int clk_run = 0, last_clk_run = 0, pulse_busy_bad = 0, fall_cyc = 0;
  logic prev_clk_oe = 1'b0, prev_done = 1'b0, busy_after_done = 1'b0;
  logic [10:0] cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return (($countones(d) % 2) == 0);
  endfunction

  // One clock cycle; outputs are observed 1 ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (prev_done) busy_after_done = busy;
    prev_done = done;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (error) begin err_cnt++; err_cyc = cyc; end
    if ((done || error) && busy) pulse_busy_bad++;
    if (ps_clk_oe) clk_run++;
    else if (prev_clk_oe) begin last_clk_run = clk_run; clk_run = 0; end
    prev_clk_oe = ps_clk_oe;
  endtask

  // Device: wait for request-to-send, then generate nclk clock pulses
  task automatic dev_clock(input int nclk, input int half, input logic ack);
    int w = 0;
    while (!(busy && !ps_clk_oe && ps_dat_oe) && w < 2000) begin tick(); w++; end
    check("rts_seen", (w < 2000), 1);
    cap = '1;
    repeat (half) tick();
    for (int k = 1; k <= nclk; k++) begin
      if (k == 1) cap[0] = ps_dat;
      if (k == 11 && ack) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      repeat (half) tick();
      dev_clk_low = 1'b0;
      if (k <= 10) cap[k] = ps_dat;
      repeat (half) tick();
      if (k == 11) dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_end(input int d0, input int e0);
    int w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 5000) begin tick(); w++; end
    check("end_seen", (w < 5000), 1);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int half);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    data = v.d;
    send = 1'b1;
    tick();
    send = 1'b0;
    data = ~v.d;
    check({tag, "_accept_busy"}, busy, 1);
    check({tag, "_accept_clk_oe"}, ps_clk_oe, 1);
    dev_clock(11, half, v.ack);
    wait_end(d0, e0);
    check({tag, "_clk_oe_len"}, last_clk_run, INH + STC);
    check({tag, "_start"}, cap[0], 0);
    check({tag, "_byte"}, cap[8:1], v.d);
    check({tag, "_parity"}, cap[9], v.par);
    check({tag, "_stop"}, cap[10], 1);
    check({tag, "_done"}, done_cnt - d0, v.exp_done);
    check({tag, "_error"}, err_cnt - e0, v.exp_err);
    check({tag, "_idle"}, {busy, ps_clk_oe, ps_dat_oe}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got time limit expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t vt[5];
    vec_t rv;
    int d0, e0;
    vt[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[1] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[4] = '{8'hA5, 1'b0, 1'b1, !ACK_CHK, ACK_CHK};

    repeat (3) tick();
    check("reset_outputs", {ps_clk_oe, ps_dat_oe, busy, done, error}, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_outputs", {ps_clk_oe, ps_dat_oe, busy, done, error}, 0);

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vt[i], 20);

    for (int i = 0; i < 10; i++) begin
      rv.d = 8'($urandom);
      rv.ack = 1'($urandom_range(0, 1));
      rv.par = odd_par(rv.d);
      rv.exp_done = rv.ack | !ACK_CHK;
      rv.exp_err = !rv.ack & ACK_CHK;
      run_vec($sformatf("rnd%0d", i), rv, $urandom_range(8, 25));
    end

    // Device stops clocking after bit 4
    d0 = done_cnt; e0 = err_cnt;
    data = 8'hED; send = 1'b1; tick(); send = 1'b0;
    dev_clock(5, 20, 1'b1);
    wait_end(d0, e0);
    check("tmo_error", err_cnt - e0, 1);
    check("tmo_no_done", done_cnt - d0, 0);
    check("tmo_latency", err_cyc - fall_cyc, 3 + TMO);
    check("tmo_lines", {ps_clk_oe, ps_dat_oe, busy}, 0);

    // send pulsed while busy is ignored
    d0 = done_cnt; e0 = err_cnt;
    data = 8'hED; send = 1'b1; tick(); send = 1'b0;
    repeat (5) tick();
    data = 8'h55; send = 1'b1; tick(); send = 1'b0;
    dev_clock(11, 20, 1'b1);
    wait_end(d0, e0);
    check("ign_byte", cap[8:1], 8'hED);
    check("ign_done", done_cnt - d0, 1);

    // send held through done restarts immediately
    busy_after_done = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    data = 8'h3C; send = 1'b1; tick();
    dev_clock(11, 15, 1'b1);
    wait_end(d0, e0);
    tick();
    check("hold_restart", busy_after_done, 1);
    send = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    dev_clock(11, 15, 1'b1);
    wait_end(d0, e0);
    check("hold_byte2", cap[8:1], 8'h3C);
    check("hold_done2", done_cnt - d0, 1);

    // Asynchronous reset in the middle of SHIFT
    d0 = done_cnt; e0 = err_cnt;
    data = 8'hED; send = 1'b1; tick(); send = 1'b0;
    dev_clock(5, 20, 1'b0);
    check("rst_pre_dat_oe", ps_dat_oe, 1);
    #5 reset_n = 1'b0;
    #1;
    check("rst_async_lines", {ps_clk_oe, ps_dat_oe, busy}, 0);
    repeat (3) tick();
    check("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    reset_n = 1'b1;
    tick();
    run_vec("post_rst", vt[1], 20);

    check("pulse_busy_low", pulse_busy_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
